// File: rtl/hb_sp_access_ctrl.sv
// Master-side sequencer: one LSU request at a time onto the XT_HBUS SystemPeripheral.
// Loads and sub-word stores read first; sub-word stores then write back the merged word.
module hb_sp_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        hb_clk,
    input  logic        rst_sync,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] hb_raddr,
    output logic [31:0] hb_waddr,
    output logic [31:0] hb_wdata,
    output logic        sel_ren,
    output logic        sel_wen,
    input  logic        read_finish,
    input  logic        write_finish,
    input  logic [31:0] slave_rdata
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic          TMO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          state, state_n;
    logic            we_q, we_n;
    logic [1:0]      size_q, size_n;
    logic [1:0]      lane_q, lane_n;
    logic [DW-1:0]   wd_q, wd_n;
    logic [DW-1:0]   raddr_n, waddr_n, hbw_n, rdata_n;
    logic            err_n;
    logic [CW-1:0]   tmo_cnt, cnt_n;
    logic            mis_c;
    logic            tmo_hit_c;

    // Replace the addressed byte/half lane of the old word with right-aligned store data.
    function automatic logic [DW-1:0] merge_lane(input logic [DW-1:0] old,
                                                 input logic [1:0]    size,
                                                 input logic [1:0]    lane,
                                                 input logic [DW-1:0] wd);
        logic [DW-1:0] r;
        r = old;
        case (size)
            2'd0: begin
                case (lane)
                    2'd0: r[7:0]   = wd[7:0];
                    2'd1: r[15:8]  = wd[7:0];
                    2'd2: r[23:16] = wd[7:0];
                    default: r[31:24] = wd[7:0];
                endcase
            end
            2'd1: begin
                if (lane[1]) r[31:16] = wd[15:0];
                else         r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    // Alignment / size legality of the incoming request.
    always_comb begin
        mis_c = ((req_size == 2'd1) && req_addr[0]) ||
                ((req_size == 2'd2) && (req_addr[1:0] != 2'b00)) ||
                (req_size == 2'd3);
    end

    // Timeout fires on the last allowed wait cycle when no finish arrives.
    always_comb begin
        tmo_hit_c = TMO_EN && (tmo_cnt == TMO_LAST);
    end

    // Next-state and next-register values.
    always_comb begin
        state_n = state;
        we_n    = we_q;
        size_n  = size_q;
        lane_n  = lane_q;
        wd_n    = wd_q;
        raddr_n = hb_raddr;
        waddr_n = hb_waddr;
        hbw_n   = hb_wdata;
        rdata_n = '0;
        err_n   = 1'b0;
        cnt_n   = tmo_cnt;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    raddr_n = {req_addr[31:2], 2'b00};
                    waddr_n = {req_addr[31:2], 2'b00};
                    we_n    = req_we;
                    size_n  = req_size;
                    lane_n  = req_addr[1:0];
                    wd_n    = req_wdata;
                    cnt_n   = '0;
                    if (mis_c) begin
                        state_n = S_RESP;
                        err_n   = 1'b1;
                    end else if (req_we && (req_size == 2'd2)) begin
                        state_n = S_WR;
                        hbw_n   = req_wdata;
                    end else begin
                        state_n = S_RD;
                    end
                end
            end
            S_RD: begin
                if (read_finish) begin
                    if (we_q) begin
                        state_n = S_WR;
                        hbw_n   = merge_lane(slave_rdata, size_q, lane_q, wd_q);
                        cnt_n   = '0;
                    end else begin
                        state_n = S_RESP;
                        rdata_n = slave_rdata;
                    end
                end else if (tmo_hit_c) begin
                    state_n = S_RESP;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = tmo_cnt + CW'(1);
                end
            end
            S_WR: begin
                if (write_finish) begin
                    state_n = S_RESP;
                end else if (tmo_hit_c) begin
                    state_n = S_RESP;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = tmo_cnt + CW'(1);
                end
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; bus strobes and handshakes follow the next state.
    always_ff @(posedge hb_clk) begin
        if (rst_sync) begin
            state     <= S_IDLE;
            we_q      <= 1'b0;
            size_q    <= 2'd0;
            lane_q    <= 2'd0;
            wd_q      <= '0;
            hb_raddr  <= '0;
            hb_waddr  <= '0;
            hb_wdata  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            tmo_cnt   <= '0;
            sel_ren   <= 1'b0;
            sel_wen   <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state     <= state_n;
            we_q      <= we_n;
            size_q    <= size_n;
            lane_q    <= lane_n;
            wd_q      <= wd_n;
            hb_raddr  <= raddr_n;
            hb_waddr  <= waddr_n;
            hb_wdata  <= hbw_n;
            rsp_valid <= (state_n == S_RESP);
            rsp_err   <= err_n;
            rsp_rdata <= rdata_n;
            tmo_cnt   <= cnt_n;
            sel_ren   <= (state_n == S_RD);
            sel_wen   <= (state_n == S_WR);
            req_ready <= (state_n == S_IDLE);
        end
    end

endmodule

// File: tb/tb_hb_sp_access_ctrl.sv
// Bench for hb_sp_access_ctrl: SP slave model, transaction-level predictor, per-cycle compare.
module tb_hb_sp_access_ctrl;

    localparam int T     = 15;
    localparam int NEVER = 100000;

    logic        hb_clk = 1'b0;
    logic        rst_sync;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] hb_raddr, hb_waddr, hb_wdata;
    logic        sel_ren, sel_wen;
    logic        read_finish, write_finish;
    logic [31:0] slave_rdata;

    hb_sp_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .hb_clk(hb_clk), .rst_sync(rst_sync),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .hb_raddr(hb_raddr), .hb_waddr(hb_waddr), .hb_wdata(hb_wdata),
        .sel_ren(sel_ren), .sel_wen(sel_wen),
        .read_finish(read_finish), .write_finish(write_finish),
        .slave_rdata(slave_rdata)
    );

    always #5 hb_clk = ~hb_clk;

    int cyc = 0;
    always @(posedge hb_clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // SP slave: finish after a programmable number of strobe cycles; memory of 256 words.
    int          rd_lat = 1;
    int          wr_lat = 0;
    int          ren_age = 0;
    int          wen_age = 0;
    logic        spur = 1'b0;
    logic [31:0] smem [256];
    logic [31:0] mm   [256];

    always_comb begin
        read_finish  = spur || (sel_ren && (ren_age == rd_lat));
        write_finish = spur || (sel_wen && (wen_age == wr_lat));
        slave_rdata  = read_finish ? smem[hb_raddr[9:2]] : 32'hDEAD_BEEF;
    end

    always @(posedge hb_clk) begin
        ren_age <= sel_ren ? ren_age + 1 : 0;
        wen_age <= sel_wen ? wen_age + 1 : 0;
        if (sel_wen && write_finish) smem[hb_waddr[9:2]] <= hb_wdata;
    end

    // Predicted transaction: cycle windows for strobes, busy span, response cycle and payload.
    int          ren_lo = 1, ren_hi = 0, wen_lo = 1, wen_hi = 0, busy_lo = 1, busy_hi = 0;
    int          rsp_at = -1;
    logic        x_err = 1'b0;
    logic [31:0] x_rdata = '0, x_addr = '0, x_wdata = '0;
    logic        cmt_pend = 1'b0;
    logic [7:0]  cmt_idx = '0;

    task automatic predict(input int t, input logic we, input logic [31:0] addr,
                           input logic [1:0] size, input logic [31:0] wd);
        logic        mis, to;
        int          rd_c, wr_c, sh;
        logic [31:0] old, nw, msk;
        mis = (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00) || size == 2'd3;
        old = mm[addr[9:2]];
        x_addr = {addr[31:2], 2'b00};
        rd_c = 0; wr_c = 0; to = 1'b0;
        if (mis) begin
            rsp_at = t + 1; x_err = 1'b1; x_rdata = '0; cmt_pend = 1'b0;
            ren_lo = 1; ren_hi = 0; wen_lo = 1; wen_hi = 0;
        end else begin
            if (!we || size != 2'd2) begin
                if (rd_lat >= T) begin rd_c = T; to = 1'b1; end
                else rd_c = rd_lat + 1;
            end
            if (we && !to) begin
                if (wr_lat >= T) begin wr_c = T; to = 1'b1; end
                else wr_c = wr_lat + 1;
            end
            if (size == 2'd0) begin sh = 8 * int'(addr[1:0]); msk = 32'hFF; end
            else if (size == 2'd1) begin sh = addr[1] ? 16 : 0; msk = 32'hFFFF; end
            else begin sh = 0; msk = 32'hFFFF_FFFF; end
            nw = (old & ~(msk << sh)) | ((wd & msk) << sh);
            ren_lo = t + 1;        ren_hi = t + rd_c;
            wen_lo = t + 1 + rd_c; wen_hi = t + rd_c + wr_c;
            rsp_at = t + 1 + rd_c + wr_c;
            x_err = to;
            x_rdata = (!we && !to) ? old : 32'h0;
            x_wdata = nw;
            cmt_pend = we && !to;
            cmt_idx = addr[9:2];
        end
        busy_lo = t + 1; busy_hi = rsp_at;
    endtask

    // Synchronous reset sampled at the end of cycle r cuts every window short.
    task automatic abort_at(input int r);
        if (ren_hi > r) ren_hi = r;
        if (wen_hi > r) wen_hi = r;
        if (busy_hi > r) busy_hi = r;
        if (rsp_at > r) begin rsp_at = -1; cmt_pend = 1'b0; end
    endtask

    // Observed statistics for the hand-computed checks.
    int          ren_cnt = 0, wen_cnt = 0, rsp_cnt = 0, last_rsp = 0;
    logic        last_err = 1'b0;
    logic [31:0] last_rdata = '0, last_waddr = '0, last_wdata = '0;
    int          acc_q [$];
    logic        chk_en = 1'b0;

    // Per-cycle compare against the predictor.
    always @(negedge hb_clk) begin
        if (chk_en) begin
            chk("sel_ren", 32'(sel_ren), 32'(cyc >= ren_lo && cyc <= ren_hi));
            chk("sel_wen", 32'(sel_wen), 32'(cyc >= wen_lo && cyc <= wen_hi));
            chk("rsp_valid", 32'(rsp_valid), 32'(cyc == rsp_at));
            chk("req_ready", 32'(req_ready), 32'(!(cyc >= busy_lo && cyc <= busy_hi)));
            if (cyc >= ren_lo && cyc <= ren_hi) chk("hb_raddr", hb_raddr, x_addr);
            if (cyc >= wen_lo && cyc <= wen_hi) begin
                chk("hb_waddr", hb_waddr, x_addr);
                chk("hb_wdata", hb_wdata, x_wdata);
            end
            if (cyc == rsp_at) begin
                chk("rsp_err", 32'(rsp_err), 32'(x_err));
                chk("rsp_rdata", rsp_rdata, x_rdata);
                if (cmt_pend) begin mm[cmt_idx] = x_wdata; cmt_pend = 1'b0; end
            end
            if (sel_ren) ren_cnt++;
            if (sel_wen) begin wen_cnt++; last_waddr = hb_waddr; last_wdata = hb_wdata; end
            if (rsp_valid) begin
                rsp_cnt++; last_rsp = cyc; last_err = rsp_err; last_rdata = rsp_rdata;
            end
        end
    end

    task automatic clr_stats();
        ren_cnt = 0; wen_cnt = 0; rsp_cnt = 0; acc_q.delete();
    endtask

    task automatic set_mem(input int idx, input logic [31:0] v);
        smem[idx] = v; mm[idx] = v;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wd);
        logic ok;
        ok = 1'b0;
        @(negedge hb_clk);
        req_we = we; req_addr = addr; req_size = size; req_wdata = wd; req_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge hb_clk);
        end
        chk("accept_wait", 32'(ok), 32'd1);
        if (!ok) begin req_valid = 1'b0; return; end
        predict(cyc, we, addr, size, wd);
        acc_q.push_back(cyc);
        @(posedge hb_clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        for (int k = 0; k < 200; k++) begin
            if (rsp_cnt >= n) break;
            @(negedge hb_clk);
            #1;
        end
        chk("rsp_seen", 32'(rsp_cnt), 32'(n));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge hb_clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) set_mem(i, 32'h0);
        rst_sync = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_size = '0; req_wdata = '0;
        repeat (3) @(negedge hb_clk);
        rst_sync = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_sel", 32'({sel_ren, sel_wen}), 32'd0);
        chk("rst_addrs", hb_raddr | hb_waddr | hb_wdata, 32'd0);
        chk("rst_rsp", rsp_rdata | 32'(rsp_err), 32'd0);
        chk_en = 1'b1;

        // Word load with a one-cycle slave.
        set_mem(16, 32'h0000_8005);
        clr_stats(); issue(1'b0, 32'h40, 2'd2, 32'h0); wait_rsp(1);
        chk("wl_latency", 32'(last_rsp - acc_q[0]), 32'd3);
        chk("wl_rdata", last_rdata, 32'h0000_8005);
        chk("wl_err", 32'(last_err), 32'd0);
        chk("wl_ren_cycles", 32'(ren_cnt), 32'd2);

        // Byte store as read-modify-write.
        set_mem(16, 32'h1122_3344);
        clr_stats(); issue(1'b1, 32'h41, 2'd0, 32'h0000_00AA); wait_rsp(1); idle(1);
        chk("bs_latency", 32'(last_rsp - acc_q[0]), 32'd4);
        chk("bs_waddr", last_waddr, 32'h40);
        chk("bs_wdata", last_wdata, 32'h1122_AA44);
        chk("bs_mem", smem[16], 32'h1122_AA44);
        chk("bs_err", 32'(last_err), 32'd0);

        // Misaligned half load.
        clr_stats(); issue(1'b0, 32'h43, 2'd1, 32'h0); wait_rsp(1);
        chk("mis_latency", 32'(last_rsp - acc_q[0]), 32'd1);
        chk("mis_err", 32'(last_err), 32'd1);
        chk("mis_no_sel", 32'(ren_cnt + wen_cnt), 32'd0);

        // Read never finishes: timeout.
        rd_lat = NEVER;
        clr_stats(); issue(1'b0, 32'h80, 2'd2, 32'h0); wait_rsp(1);
        chk("to_ren_cycles", 32'(ren_cnt), 32'd15);
        chk("to_err", 32'(last_err), 32'd1);
        chk("to_rdata", last_rdata, 32'h0);
        chk("to_no_wen", 32'(wen_cnt), 32'd0);

        // Finish on the timeout-limit cycle wins.
        rd_lat = T - 1;
        clr_stats(); issue(1'b0, 32'h40, 2'd2, 32'h0); wait_rsp(1);
        chk("lim_err", 32'(last_err), 32'd0);
        chk("lim_rdata", last_rdata, 32'h1122_AA44);
        chk("lim_latency", 32'(last_rsp - acc_q[0]), 32'd16);

        // Sub-word store whose read times out: no write.
        rd_lat = NEVER;
        set_mem(17, 32'h9988_7766);
        clr_stats(); issue(1'b1, 32'h46, 2'd1, 32'h0000_5566); wait_rsp(1); idle(1);
        chk("rmwto_no_wen", 32'(wen_cnt), 32'd0);
        chk("rmwto_mem", smem[17], 32'h9988_7766);

        // Half store upper lane, byte store lane 3, illegal size, misaligned word.
        rd_lat = 1;
        clr_stats(); issue(1'b1, 32'h46, 2'd1, 32'h0000_5566); wait_rsp(1); idle(1);
        chk("hs_mem", smem[17], 32'h5566_7766);
        set_mem(18, 32'hCAFE_F00D);
        clr_stats(); issue(1'b1, 32'h4B, 2'd0, 32'hFFFF_FF12); wait_rsp(1); idle(1);
        chk("b3_mem", smem[18], 32'h12FE_F00D);
        clr_stats(); issue(1'b0, 32'h50, 2'd3, 32'h0); wait_rsp(1);
        clr_stats(); issue(1'b1, 32'h52, 2'd2, 32'h1234_5678); wait_rsp(1);
        chk("mw_mem", smem[20], 32'h0);

        // Word store with a slow write, then a load of it back.
        wr_lat = 2;
        clr_stats(); issue(1'b1, 32'h54, 2'd2, 32'hA5A5_5A5A); wait_rsp(1);
        chk("slow_wr_latency", 32'(last_rsp - acc_q[0]), 32'd4);
        wr_lat = 0;
        clr_stats(); issue(1'b0, 32'h54, 2'd2, 32'h0); wait_rsp(1);

        // Finish strobes while idle are ignored.
        @(negedge hb_clk); spur = 1'b1;
        idle(3);
        spur = 1'b0;
        idle(2);

        // Reset during the read phase of a sub-word store.
        rd_lat = 5;
        set_mem(33, 32'h0102_0304);
        clr_stats(); issue(1'b1, 32'h86, 2'd1, 32'h0000_BEEF);
        idle(2);
        rst_sync = 1'b1; abort_at(cyc);
        @(negedge hb_clk); rst_sync = 1'b0;
        chk("rst_sel_low", 32'({sel_ren, sel_wen}), 32'd0);
        idle(8);
        chk("rst_no_rsp", 32'(rsp_cnt), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_mem", smem[33], 32'h0102_0304);

        // Three back-to-back word stores.
        rd_lat = 1;
        clr_stats();
        issue(1'b1, 32'h60, 2'd2, 32'h1111_1111);
        issue(1'b1, 32'h64, 2'd2, 32'h2222_2222);
        issue(1'b1, 32'h68, 2'd2, 32'h3333_3333);
        wait_rsp(3); idle(1);
        if (acc_q.size() == 3) begin
            chk("b2b_gap1", 32'(acc_q[1] - acc_q[0]), 32'd3);
            chk("b2b_gap2", 32'(acc_q[2] - acc_q[1]), 32'd3);
        end else begin
            chk("b2b_accepts", 32'(acc_q.size()), 32'd3);
        end
        chk("b2b_wen", 32'(wen_cnt), 32'd3);
        chk("b2b_mem", smem[26], 32'h3333_3333);

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
